dmem_responder: RTL and testbench
=================================

# dmem_responder

Responder end of the CPU data-memory interface: accepts one load or store request at a time from the core's memory stage over a valid/ready handshake. It performs the access on an internal doubleword array and returns the response after a fixed, parameterised latency, also over valid/ready. It replaces the zero-latency data memory when the core runs with a stalling memory stage, and flags misaligned or out-of-range addresses instead of silently aliasing.

## Interface
- DEPTH, 128: number of 64-bit doublewords in the array; power of two, 2..4096
- LATENCY, 2: cycles from request acceptance to rsp_valid_o; 1..15
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  synchronous, active-high reset
- req_valid_i  input  1  request present
- req_ready_o  output  1  responder can accept a request this cycle
- req_we_i  input  1  1 = store, 0 = load
- req_addr_i  input  64  byte address
- req_wdata_i  input  64  store data
- req_be_i  input  8  store byte enables; bit n covers wdata[8n+7:8n]
- rsp_valid_o  output  1  response present
- rsp_ready_i  input  1  core accepts the response
- rsp_rdata_o  output  64  load data; 0 for stores and for errors
- rsp_err_o  output  1  request was misaligned or out of range

## Operation
- States:
  - IDLE: req_ready_o=1.
  - BUSY: latency countdown.
  - RESP: rsp_valid_o=1.
- Accept: IDLE with req_valid_i=1 at a rising edge.
  - LATENCY=1: go to RESP.
  - Otherwise: go to BUSY and load the counter with LATENCY-1.
- BUSY: decrement the counter each cycle; on reaching 0, go to RESP.
- RESP: hold rsp_valid_o, rsp_rdata_o and rsp_err_o stable until rsp_ready_i=1, then go to IDLE.
- Error check at acceptance:
  - err = (req_addr_i[2:0] != 0) or (req_addr_i[63:3] >= DEPTH).
- Store, no error: at the acceptance edge, write the array word at index req_addr_i[3+log2(DEPTH)-1:3], updating only the bytes whose req_be_i bit is set. req_be_i = 0 is a legal no-op store with err=0.
- Load, no error: capture the full doubleword into the response register at the acceptance edge. req_be_i is ignored for loads.
- Error: no array write; rdata = 0; err = 1.
- Only one request is outstanding. Inputs on the request side are ignored outside IDLE.

## Timing
- Reset values:
  - req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - Counter = 0; state = IDLE.
- req_ready_o rises in the first cycle after rst_i deasserts.
- Array contents are not affected by reset.
- Acceptance at edge T: rsp_valid_o is high from cycle T+LATENCY onward.
- Response handshake at edge R: rsp_valid_o=0 and req_ready_o=1 from cycle R+1. There is no back-to-back accept in the handshake cycle, so minimum request spacing is LATENCY+1 cycles.
- Outputs are registered; no combinational path from any input to any output.
- Reset mid-operation (BUSY or RESP):
  - The transaction is abandoned with no response.
  - A store accepted before reset stays committed.
- A store followed by a load to the same address returns the stored bytes (the write is complete before the next accept).

## Structure
- Package dmem_pkg holds:
  - the state enum (IDLE, BUSY, RESP)
  - localparams for the LATENCY and DEPTH bounds
  - the function computing the index width from DEPTH
- Sub-module dmem_array (DEPTH x 64, synchronous byte-masked write port, asynchronous read port) isolates the storage so an SRAM macro can replace it.
- FSM, counter, error check and response registers live in dmem_responder.

## Test plan
- LATENCY=2. Store addr 0x10, wdata 0x1122334455667788, be 0xFF; then load 0x10.
  - Each rsp_valid_o rises 2 cycles after its accept.
  - Load returns 0x1122334455667788 with err=0.
- Preload addr 0x08 with 0xFFFFFFFFFFFFFFFF; store 0x0000000000AB0000 with be 0x04; load 0x08.
  - Load returns 0xFFFFFFFFFFABFFFF.
- Load addr 0x0C: rsp_err_o=1, rdata=0. Store addr 0x400 with DEPTH=128: err=1, array unchanged (a load of 0x000 still returns its prior value).
- Hold rsp_ready_i=0 for 5 cycles after rsp_valid_o rises.
  - rsp_valid_o and rsp_rdata_o stay constant; req_ready_o stays 0.
  - req_ready_o returns 1 the cycle after rsp_ready_i=1.
- LATENCY=4. Assert rst_i for one cycle while in BUSY after a store to 0x20.
  - No response appears.
  - req_ready_o=1 one cycle after reset release.
  - A later load of 0x20 returns the stored data.
- LATENCY=1, load with rsp_ready_i tied to 1: rsp_valid_o pulses for exactly one cycle; accepts occur every 2 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types, parameter bounds and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 15;
  localparam int unsigned DEPTH_MIN   = 2;
  localparam int unsigned DEPTH_MAX   = 4096;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64 doubleword storage: synchronous byte-masked write, asynchronous read.
// Kept separate so an SRAM macro can be dropped in without touching the FSM.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int unsigned DEPTH = 128,
  localparam int unsigned IDX_W = idx_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [63:0]      wdata_i,
  input  logic [7:0]       be_i,
  output logic [63:0]      rdata_o
);

  // NOTE: storage has no reset; contents must survive a core reset and a
  // reset port would also prevent mapping onto an SRAM macro.
  logic [63:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 8; b++) begin
        if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the core data-memory interface: one outstanding request,
// fixed-latency response, misaligned/out-of-range accesses flagged as errors.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  input  logic [7:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned IDX_W = idx_width(DEPTH);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("dmem_responder: LATENCY out of range");
  end
  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dmem_responder: DEPTH must be a power of two in range");
  end

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic             accept;
  logic             addr_err;
  logic             arr_we;
  logic [IDX_W-1:0] idx;
  logic [63:0]      arr_rdata;

  // ready_q is only ever set while idle, so it doubles as the accept qualifier.
  assign accept   = req_valid_i & ready_q;
  assign idx      = req_addr_i[3 +: IDX_W];
  assign addr_err = (|req_addr_i[2:0]) | (|req_addr_i[63:3+IDX_W]);
  assign arr_we   = accept & req_we_i & ~addr_err & ~rst_i;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .idx_i   (idx),
    .wdata_i (req_wdata_i),
    .be_i    (req_be_i),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default here so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rdata_d = (req_we_i || addr_err) ? 64'd0 : arr_rdata;
          err_d   = addr_err;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_RESP);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (LATENCY 2, 4, 1) share
// one clock; drivers push expected responses, per-instance monitors check them.
module tb_dmem_responder;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst       [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [63:0] req_addr  [3];
  logic [63:0] req_wdata [3];
  logic [7:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [63:0] rsp_rdata [3];
  logic        rsp_err   [3];

  exp_t exp_q [3][$];
  int   hs_cnt   [3];
  int   n_iss    [3];
  int   last_acc [3];
  int   cyc;
  int   n_cmp;
  int   n_fail;

  localparam logic [63:0] D1 = 64'h1122334455667788;
  localparam logic [63:0] D3 = 64'hCAFEF00D12345678;
  localparam logic [63:0] D4 = 64'h0F1E2D3C4B5A6978;
  localparam logic [63:0] DA = 64'hA5A5A5A55A5A5A5A;
  localparam logic [63:0] DL = 64'h0123456789ABCDEF;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 4 : 1;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(.DEPTH(128), .LATENCY(lat_of(g))) u_dut (
      .clk_i       (clk),
      .rst_i       (rst[g]),
      .req_valid_i (req_valid[g]),
      .req_ready_o (req_ready[g]),
      .req_we_i    (req_we[g]),
      .req_addr_i  (req_addr[g]),
      .req_wdata_i (req_wdata[g]),
      .req_be_i    (req_be[g]),
      .rsp_valid_o (rsp_valid[g]),
      .rsp_ready_i (rsp_ready[g]),
      .rsp_rdata_o (rsp_rdata[g]),
      .rsp_err_o   (rsp_err[g])
    );

    bit   in_rsp = 1'b0;
    bit   expect_idle = 1'b0;
    exp_t cur;

    // Monitor: pop on the first valid cycle, then insist the response holds.
    always @(negedge clk) begin
      if (rst[g]) begin
        in_rsp      = 1'b0;
        expect_idle = 1'b0;
      end else begin
        if (expect_idle) begin
          check($sformatf("d%0d_post_hs_valid", g), 64'(rsp_valid[g]), 64'd0);
          check($sformatf("d%0d_post_hs_ready", g), 64'(req_ready[g]), 64'd1);
          expect_idle = 1'b0;
        end
        if (rsp_valid[g]) begin
          if (!in_rsp) begin
            if (exp_q[g].size() == 0) begin
              check($sformatf("d%0d_unexpected_rsp", g), 64'(rsp_valid[g]), 64'd0);
            end else begin
              cur    = exp_q[g].pop_front();
              in_rsp = 1'b1;
              check($sformatf("d%0d_rdata", g), rsp_rdata[g], cur.rdata);
              check($sformatf("d%0d_err", g), 64'(rsp_err[g]), 64'(cur.err));
              check($sformatf("d%0d_latency_cycle", g), 64'(cyc), 64'(cur.cyc));
            end
          end else begin
            check($sformatf("d%0d_hold_rdata", g), rsp_rdata[g], cur.rdata);
            check($sformatf("d%0d_hold_err", g), 64'(rsp_err[g]), 64'(cur.err));
            check($sformatf("d%0d_hold_req_ready", g), 64'(req_ready[g]), 64'd0);
          end
          if (rsp_ready[g]) begin
            expect_idle = 1'b1;
            in_rsp      = 1'b0;
            hs_cnt[g]++;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  task automatic issue(input int d, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] be,
                       input logic [63:0] e_rdata, input logic e_err, input bit chk_gap);
    bit   got;
    exp_t e;
    @(posedge clk);
    #1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    req_valid[d] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready[d]) got = 1'b1;
    end
    if (!got) begin
      fail($sformatf("d%0d_accept_timeout", d));
    end else begin
      e.rdata = e_rdata;
      e.err   = e_err;
      e.cyc   = cyc + lat_of(d);
      exp_q[d].push_back(e);
      n_iss[d]++;
      if (chk_gap) check($sformatf("d%0d_accept_gap", d), 64'(cyc - last_acc[d]), 64'd2);
      last_acc[d] = cyc;
    end
  endtask

  task automatic req_idle(input int d);
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
  endtask

  task automatic wait_all(input int d);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (hs_cnt[d] == n_iss[d]) done = 1'b1;
    end
    if (!done) fail($sformatf("d%0d_rsp_timeout", d));
  endtask

  task automatic xfer(input int d, input logic we, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [7:0] be,
                      input logic [63:0] e_rdata, input logic e_err);
    issue(d, we, addr, wdata, be, e_rdata, e_err, 1'b0);
    req_idle(d);
    wait_all(d);
  endtask

  initial begin
    bit seen;
    n_cmp  = 0;
    n_fail = 0;
    for (int d = 0; d < 3; d++) begin
      rst[d]       = 1'b1;
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = 64'd0;
      req_wdata[d] = 64'd0;
      req_be[d]    = 8'd0;
      rsp_ready[d] = 1'b1;
      hs_cnt[d]    = 0;
      n_iss[d]     = 0;
      last_acc[d]  = 0;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d_rst_req_ready", d), 64'(req_ready[d]), 64'd0);
      check($sformatf("d%0d_rst_rsp_valid", d), 64'(rsp_valid[d]), 64'd0);
      check($sformatf("d%0d_rst_rdata", d), rsp_rdata[d], 64'd0);
      check($sformatf("d%0d_rst_err", d), 64'(rsp_err[d]), 64'd0);
    end
    @(posedge clk);
    #1 for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("d%0d_ready_after_rst", d), 64'(req_ready[d]), 64'd1);

    // LATENCY=2: full store then load back.
    xfer(0, 1'b1, 64'h10, D1, 8'hFF, 64'd0, 1'b0);
    xfer(0, 1'b0, 64'h10, 64'd0, 8'h00, D1, 1'b0);
    // Single-byte store into an all-ones word.
    xfer(0, 1'b1, 64'h08, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1'b0);
    xfer(0, 1'b1, 64'h08, 64'h0000_0000_00AB_0000, 8'h04, 64'd0, 1'b0);
    xfer(0, 1'b0, 64'h08, 64'd0, 8'hFF, 64'hFFFF_FFFF_FFAB_FFFF, 1'b0);
    // Errors: misaligned load, out-of-range store must not alias onto index 0.
    xfer(0, 1'b1, 64'h00, DA, 8'hFF, 64'd0, 1'b0);
    xfer(0, 1'b0, 64'h0C, 64'd0, 8'h00, 64'd0, 1'b1);
    xfer(0, 1'b1, 64'h400, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 64'd0, 1'b1);
    xfer(0, 1'b0, 64'h00, 64'd0, 8'h00, DA, 1'b0);
    // Last valid index, high address bit set, zero-enable store is a no-op.
    xfer(0, 1'b1, 64'h3F8, DL, 8'hFF, 64'd0, 1'b0);
    xfer(0, 1'b0, 64'h3F8, 64'd0, 8'h00, DL, 1'b0);
    xfer(0, 1'b0, 64'h8000_0000_0000_0010, 64'd0, 8'h00, 64'd0, 1'b1);
    xfer(0, 1'b1, 64'h10, 64'hFFFF_0000_FFFF_0000, 8'h00, 64'd0, 1'b0);
    xfer(0, 1'b0, 64'h10, 64'd0, 8'hFF, D1, 1'b0);

    // Back-pressure: response held for five cycles with rsp_ready low.
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 64'h08, 64'd0, 8'h00, 64'hFFFF_FFFF_FFAB_FFFF, 1'b0, 1'b0);
    req_idle(0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) seen = 1'b1;
    end
    if (!seen) fail("d0_hold_valid_timeout");
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 rsp_ready[0] = 1'b1;
    wait_all(0);

    // LATENCY=4: reset while BUSY abandons the response but keeps the store.
    issue(1, 1'b1, 64'h20, D3, 8'hFF, 64'd0, 1'b0, 1'b0);
    req_idle(1);
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    exp_q[1].delete();
    n_iss[1]--;
    @(posedge clk);
    #1 rst[1] = 1'b0;
    @(negedge clk);
    check("d1_rst_mid_req_ready", 64'(req_ready[1]), 64'd0);
    check("d1_rst_mid_rsp_valid", 64'(rsp_valid[1]), 64'd0);
    @(negedge clk);
    check("d1_ready_after_mid_rst", 64'(req_ready[1]), 64'd1);
    repeat (8) @(negedge clk);
    xfer(1, 1'b0, 64'h20, 64'd0, 8'h00, D3, 1'b0);

    // LATENCY=1 with rsp_ready tied high: accepts every second cycle.
    xfer(2, 1'b1, 64'h18, D4, 8'hFF, 64'd0, 1'b0);
    issue(2, 1'b0, 64'h18, 64'd0, 8'h00, D4, 1'b0, 1'b0);
    issue(2, 1'b0, 64'h18, 64'd0, 8'h00, D4, 1'b0, 1'b1);
    issue(2, 1'b0, 64'h1C, 64'd0, 8'h00, 64'd0, 1'b1, 1'b1);
    req_idle(2);
    wait_all(2);

    repeat (4) @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("d%0d_sb_drain", d), 64'(exp_q[d].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "timeout");
  end

endmodule
